// File: rtl/wb_flash_ctrl_pkg.sv
// wb_flash_ctrl_pkg: shared FSM state type and bus widths for the Wishbone-to-NOR-flash read bridge
package wb_flash_ctrl_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int FLASH_DW = 8;
  typedef enum logic [1:0] {IDLE, READ, ACK} state_e;
endpackage

// File: rtl/wb_flash_ctrl_if.sv
// wb_flash_ctrl_if: Wishbone classic bus bundle (cyc/stb/we/addr/data/sel in, data/ack out) with master and slave modports
interface wb_flash_ctrl_if;
  import wb_flash_ctrl_pkg::*;
  logic wb_cyc_i;
  logic wb_stb_i;
  logic wb_we_i;
  logic [WB_AW-1:0] wb_addr_i;
  logic [WB_DW-1:0] wb_data_i;
  logic [3:0] wb_sel_i;
  logic [WB_DW-1:0] wb_data_o;
  logic wb_ack_o;
  modport master(output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i, input wb_data_o, wb_ack_o);
  modport slave(input wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i, output wb_data_o, wb_ack_o);
endinterface

// File: rtl/wb_flash_ctrl.sv
// wb_flash_ctrl: Wishbone slave (wb bus, wb_clk_i, wb_rst_i) reading 32-bit big-endian words as 4 wait-stated byte reads from 8-bit NOR flash (flash_data_i, flash_addr_o, flash_we_o/rst_o/oe_o/ce_o active-low); writes are acked only
module wb_flash_ctrl
  import wb_flash_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int FLASH_AW = 21
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wb_flash_ctrl_if.slave wb,
  input  logic [FLASH_DW-1:0] flash_data_i,
  output logic [FLASH_AW-1:0] flash_addr_o,
  output logic flash_we_o,
  output logic flash_rst_o,
  output logic flash_oe_o,
  output logic flash_ce_o
);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  state_e state_q;
  logic [1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [WB_DW-1:0] data_q;
  logic ack_q;
  logic ce_q;
  logic rst_q;
  logic [FLASH_AW-1:0] addr_q;
  logic req;
  logic last;
  assign req = wb.wb_cyc_i & wb.wb_stb_i;
  assign last = cnt_q == CW'(WAIT_CYCLES - 1);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      ack_q <= 1'b0;
      ce_q <= 1'b1;
      rst_q <= 1'b0;
      addr_q <= '0;
    end else begin
      rst_q <= 1'b1;
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (req && !ack_q) begin
          if (wb.wb_we_i) begin
            state_q <= ACK;
            ack_q <= 1'b1;
          end else begin
            state_q <= READ;
            idx_q <= '0;
            cnt_q <= '0;
            ce_q <= 1'b0;
            addr_q <= {wb.wb_addr_i[FLASH_AW-1:2], 2'b00};
          end
        end
        READ: if (!req) begin
          state_q <= IDLE;
          ce_q <= 1'b1;
        end else if (last) begin
          data_q[{~idx_q, 3'b000} +: 8] <= flash_data_i;
          cnt_q <= '0;
          idx_q <= idx_q + 2'd1;
          addr_q[1:0] <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= ACK;
            ack_q <= 1'b1;
            ce_q <= 1'b1;
          end
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wb.wb_data_o = data_q;
  assign wb.wb_ack_o = ack_q;
  assign flash_addr_o = addr_q;
  assign flash_we_o = 1'b1;
  assign flash_rst_o = rst_q;
  assign flash_oe_o = ce_q;
  assign flash_ce_o = ce_q;
endmodule

// File: tb/tb_wb_flash_ctrl.sv
// tb_wb_flash_ctrl: directed bench for wb_flash_ctrl with a flash model returning the low address byte
module tb_wb_flash_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wb_flash_ctrl_if bus();
  wb_flash_ctrl_if bus1();
  logic [20:0] fa, fa1;
  logic fwe, frst, foe, fce, fwe1, frst1, foe1, fce1;
  logic [7:0] fd, fd1;
  assign fd = fa[7:0];
  assign fd1 = fa1[7:0];
  wb_flash_ctrl #(.WAIT_CYCLES(5), .FLASH_AW(21)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus), .flash_data_i(fd), .flash_addr_o(fa),
    .flash_we_o(fwe), .flash_rst_o(frst), .flash_oe_o(foe), .flash_ce_o(fce));
  wb_flash_ctrl #(.WAIT_CYCLES(1), .FLASH_AW(21)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus1), .flash_data_i(fd1), .flash_addr_o(fa1),
    .flash_we_o(fwe1), .flash_rst_o(frst1), .flash_oe_o(foe1), .flash_ce_o(fce1));
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [20:0] base;
    int lat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];
  int total = 0;
  int passed = 0;
  logic [20:0] last_base = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input string n, input logic we, input logic [31:0] a, input logic [20:0] base,
                      input int lat, input logic [31:0] exp);
    int c;
    logic bad;
    c = 0;
    bad = 1'b0;
    bus.wb_we_i = we;
    bus.wb_addr_i = a;
    bus.wb_data_i = 32'hDEADBEEF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    do begin
      step();
      c++;
      if (!bus.wb_ack_o) begin
        if (we) bad |= (fce !== 1'b1 || foe !== 1'b1 || fa !== last_base);
        else bad |= (fce !== 1'b0 || foe !== 1'b0 || fa !== base + 21'((c - 1) / 5));
      end
    end while (!bus.wb_ack_o && c < 100);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    chk({n, " latency"}, 32'(c), 32'(lat));
    chk({n, " data"}, bus.wb_data_o, exp);
    chk({n, " flash_seq"}, {31'b0, bad}, 32'd0);
    chk({n, " ce_oe_at_ack"}, {30'b0, fce, foe}, 32'd3);
    step();
    chk({n, " ack_pulse"}, {31'b0, bus.wb_ack_o}, 32'd0);
    if (!we) last_base = base;
  endtask
  initial begin
    int c;
    logic bad;
    vecs[0] = '{1'b0, 32'h0000_0104, 21'h104, 21, 32'h0405_0607};
    vecs[1] = '{1'b1, 32'h0000_0010, 21'h0, 1, 32'h0405_0607};
    vecs[2] = '{1'b0, 32'h0000_0000, 21'h0, 21, 32'h0001_0203};
    vecs[3] = '{1'b0, 32'h001F_FFFE, 21'h1F_FFFC, 21, 32'hFCFD_FEFF};
    vecs[4] = '{1'b0, 32'hFFE0_000B, 21'h8, 21, 32'h0809_0A0B};
    vecs[5] = '{1'b1, 32'h0000_0000, 21'h0, 1, 32'h0809_0A0B};
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_addr_i = 0; bus.wb_data_i = 0; bus.wb_sel_i = 4'hF;
    bus1.wb_cyc_i = 0; bus1.wb_stb_i = 0; bus1.wb_we_i = 0; bus1.wb_addr_i = 0; bus1.wb_data_i = 0; bus1.wb_sel_i = 4'hF;
    repeat (3) step();
    chk("rst ack", {31'b0, bus.wb_ack_o}, 0);
    chk("rst data", bus.wb_data_o, 0);
    chk("rst ce_oe_we", {29'b0, fce, foe, fwe}, 32'd7);
    chk("rst flash_rst", {31'b0, frst}, 0);
    chk("rst addr", {11'b0, fa}, 0);
    rst = 1'b0;
    chk("rst_o before edge", {31'b0, frst}, 0);
    step();
    chk("rst_o after release", {31'b0, frst}, 1);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].we) last_base = fa === last_base ? last_base : last_base;
      xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].base, vecs[i].lat, vecs[i].exp);
      step();
    end
    bus.wb_we_i = 1'b0;
    bus.wb_addr_i = 32'h40;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (8) step();
    chk("abort ce_in_read", {31'b0, fce}, 0);
    bus.wb_stb_i = 1'b0;
    step();
    chk("abort ce_oe", {30'b0, fce, foe}, 32'd3);
    bus.wb_cyc_i = 1'b0;
    bad = 1'b0;
    repeat (25) begin
      step();
      bad |= bus.wb_ack_o;
    end
    chk("abort no_ack", {31'b0, bad}, 0);
    chk("abort partial", bus.wb_data_o, 32'h4009_0A0B);
    xfer("after_abort", 1'b0, 32'h20, 21'h20, 21, 32'h2021_2223);
    step();
    bus.wb_we_i = 1'b0;
    bus.wb_addr_i = 32'h0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    c = 0;
    do begin step(); c++; end while (!bus.wb_ack_o && c < 100);
    chk("b2b first_lat", 32'(c), 21);
    chk("b2b first_data", bus.wb_data_o, 32'h0001_0203);
    bus.wb_addr_i = 32'h4;
    step();
    chk("b2b idle_gap", {31'b0, bus.wb_ack_o}, 0);
    c = 1;
    do begin step(); c++; end while (!bus.wb_ack_o && c < 100);
    chk("b2b second_gap", 32'(c), 22);
    chk("b2b second_data", bus.wb_data_o, 32'h0405_0607);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (2) step();
    bus.wb_addr_i = 32'h104;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (10) step();
    rst = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    step();
    chk("midrst ack_data", {31'b0, bus.wb_ack_o} | bus.wb_data_o, 0);
    chk("midrst ce_oe_rst", {29'b0, fce, foe, frst}, 32'd6);
    chk("midrst addr", {11'b0, fa}, 0);
    rst = 1'b0;
    step();
    bus1.wb_addr_i = 32'h30;
    bus1.wb_cyc_i = 1'b1;
    bus1.wb_stb_i = 1'b1;
    c = 0;
    do begin step(); c++; end while (!bus1.wb_ack_o && c < 100);
    bus1.wb_cyc_i = 1'b0;
    bus1.wb_stb_i = 1'b0;
    chk("w1 latency", 32'(c), 5);
    chk("w1 data", bus1.wb_data_o, 32'h3031_3233);
    step();
    chk("w1 ack_pulse", {31'b0, bus1.wb_ack_o}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
